// File: rtl/traffic_signal_monitor_if.sv
// rtl/traffic_signal_monitor_if.sv - controller codes in, lamp drive and fault status out
// fault_count is present only when FAULT_COUNT_EN is defined.
interface traffic_signal_monitor_if;
  logic [2:0] highway;
  logic [2:0] side_road;
  logic       clear_fault;
  logic [2:0] hw_lamp;
  logic [2:0] sr_lamp;
  logic       fault;
  logic [1:0] fault_code;
`ifdef FAULT_COUNT_EN
  logic [7:0] fault_count;

  modport master (
    output highway, side_road, clear_fault,
    input  hw_lamp, sr_lamp, fault, fault_code, fault_count
  );
  modport slave (
    input  highway, side_road, clear_fault,
    output hw_lamp, sr_lamp, fault, fault_code, fault_count
  );
`else
  modport master (
    output highway, side_road, clear_fault,
    input  hw_lamp, sr_lamp, fault, fault_code
  );
  modport slave (
    input  highway, side_road, clear_fault,
    output hw_lamp, sr_lamp, fault, fault_code
  );
`endif
endinterface

// File: rtl/traffic_signal_monitor.sv
// rtl/traffic_signal_monitor.sv - lamp driver that mirrors the controller or flashes red on faults
// Optional saturating fault-entry counter enabled by FAULT_COUNT_EN.
module traffic_signal_monitor #(
  parameter int BLINK_DIV  = 4,
  parameter int CLEAR_HOLD = 2,
  parameter int WATCHDOG   = 64
) (
  input logic                     clk,
  input logic                     rst_n,
  traffic_signal_monitor_if.slave bus
);
  localparam int BLINK_W = $clog2(2 * BLINK_DIV + 1);
  localparam int HOLD_W  = $clog2(CLEAR_HOLD + 1);
  localparam int WD_W    = $clog2(WATCHDOG + 1);

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_DIV);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(CLEAR_HOLD - 1);
  localparam logic [WD_W-1:0]    WD_LIMIT   = WD_W'(WATCHDOG);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] OFF = 3'b000;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_CONFLICT = 2'b10;
  localparam logic [1:0] CAUSE_WATCHDOG = 2'b11;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_PASS,
    ST_FAULT,
    ST_RECOVER
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         hw_in_q, hw_in_d, sr_in_q, sr_in_d;
  logic [2:0]         hw_prev_q, hw_prev_d, sr_prev_q, sr_prev_d;
  logic [2:0]         hw_lamp_q, hw_lamp_d, sr_lamp_q, sr_lamp_d;
  logic               fault_q, fault_d;
  logic [1:0]         code_q, code_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic               illegal, conflict, wd_trip, fault_now, entering_fault;
  logic [1:0]         cause;
  logic [WD_W-1:0]    wd_next;

  function automatic logic is_onehot(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

  always_comb begin
    hw_in_d   = bus.highway;
    sr_in_d   = bus.side_road;
    hw_prev_d = hw_in_q;
    sr_prev_d = sr_in_q;
    state_d   = state_q;
    hold_d    = hold_q;
    blink_d   = blink_q;
    code_d    = code_q;

    illegal  = !is_onehot(hw_in_q) || !is_onehot(sr_in_q);
    conflict = !illegal && (hw_in_q != RED) && (sr_in_q != RED);

    // The watchdog looks at the registered copy, so a change is seen against its previous value.
    if ({hw_in_q, sr_in_q} != {hw_prev_q, sr_prev_q}) begin
      wd_next = '0;
    end else if (wd_q == WD_LIMIT) begin
      wd_next = wd_q;
    end else begin
      wd_next = wd_q + WD_W'(1);
    end
    wd_trip = (state_q == ST_PASS) && (wd_next == WD_LIMIT);

    if (illegal) begin
      cause = CAUSE_ILLEGAL;
    end else if (conflict) begin
      cause = CAUSE_CONFLICT;
    end else if (wd_trip) begin
      cause = CAUSE_WATCHDOG;
    end else begin
      cause = CAUSE_NONE;
    end
    fault_now = (cause != CAUSE_NONE);

    case (state_q)
      ST_STARTUP, ST_RECOVER: begin
        if (fault_now) begin
          state_d = ST_FAULT;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_PASS;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_PASS: begin
        if (fault_now) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BLINK_W'(1);
        if (bus.clear_fault && !illegal && !conflict) begin
          state_d = ST_RECOVER;
          hold_d  = '0;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    entering_fault = (state_d == ST_FAULT) && (state_q != ST_FAULT);
    if (entering_fault) begin
      blink_d = '0;
      code_d  = cause;
    end else if (state_d == ST_PASS) begin
      code_d = CAUSE_NONE;
    end

    wd_d = ((state_q == ST_PASS) && (state_d == ST_PASS)) ? wd_next : '0;

    // Lamps follow the state being entered, so a fault suppresses the mirrored value on the same edge.
    case (state_d)
      ST_PASS: begin
        hw_lamp_d = hw_in_q;
        sr_lamp_d = sr_in_q;
      end
      ST_FAULT: begin
        hw_lamp_d = (blink_d < BLINK_HALF) ? RED : OFF;
        sr_lamp_d = (blink_d < BLINK_HALF) ? RED : OFF;
      end
      default: begin
        hw_lamp_d = RED;
        sr_lamp_d = RED;
      end
    endcase

    fault_d = (state_d == ST_FAULT) || (state_d == ST_RECOVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STARTUP;
      hw_in_q   <= RED;
      sr_in_q   <= RED;
      hw_prev_q <= RED;
      sr_prev_q <= RED;
      hw_lamp_q <= RED;
      sr_lamp_q <= RED;
      fault_q   <= 1'b0;
      code_q    <= CAUSE_NONE;
      blink_q   <= '0;
      hold_q    <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      hw_in_q   <= hw_in_d;
      sr_in_q   <= sr_in_d;
      hw_prev_q <= hw_prev_d;
      sr_prev_q <= sr_prev_d;
      hw_lamp_q <= hw_lamp_d;
      sr_lamp_q <= sr_lamp_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      blink_q   <= blink_d;
      hold_q    <= hold_d;
      wd_q      <= wd_d;
    end
  end

  assign bus.hw_lamp    = hw_lamp_q;
  assign bus.sr_lamp    = sr_lamp_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

`ifdef FAULT_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (entering_fault && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.fault_count = count_q;
`endif
endmodule

// File: tb/tb_traffic_signal_monitor.sv
// tb/tb_traffic_signal_monitor.sv - directed vector table plus watchdog and async-reset sequences
// Checks fault_count too when FAULT_COUNT_EN is defined.
module tb_traffic_signal_monitor;
  logic clk;
  logic rst_n;

  traffic_signal_monitor_if bus ();

  traffic_signal_monitor dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] hw;
    logic [2:0] sr;
    logic       clr;
    logic [2:0] ehw;
    logic [2:0] esr;
    logic       ef;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input int n, input logic [2:0] hw, input logic [2:0] sr, input logic clr,
                     input logic [2:0] ehw, input logic [2:0] esr, input logic ef,
                     input logic [1:0] ec);
    vec_t v;
    v.hw = hw; v.sr = sr; v.clr = clr;
    v.ehw = ehw; v.esr = esr; v.ef = ef; v.ec = ec;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] hw, input logic [2:0] sr, input logic clr);
    bus.highway     = hw;
    bus.side_road   = sr;
    bus.clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] ehw, input logic [2:0] esr,
                         input logic ef, input logic [1:0] ec);
    chk({tag, " lamps"}, {2'b00, bus.hw_lamp, bus.sr_lamp}, {2'b00, ehw, esr});
    chk({tag, " fault"}, {7'd0, bus.fault}, {7'd0, ef});
    chk({tag, " code"}, {6'd0, bus.fault_code}, {6'd0, ec});
  endtask

  initial begin
    // Normal cycle; lamps lag the inputs by one edge after two all-red cycles.
    add(1, 3'b001, 3'b100, 0, 3'b100, 3'b100, 0, 2'b00);
    add(8, 3'b001, 3'b100, 0, 3'b001, 3'b100, 0, 2'b00);
    add(1, 3'b010, 3'b100, 0, 3'b001, 3'b100, 0, 2'b00);
    add(1, 3'b010, 3'b100, 0, 3'b010, 3'b100, 0, 2'b00);
    add(1, 3'b100, 3'b001, 0, 3'b010, 3'b100, 0, 2'b00);
    add(3, 3'b100, 3'b001, 0, 3'b100, 3'b001, 0, 2'b00);
    add(1, 3'b100, 3'b010, 0, 3'b100, 3'b001, 0, 2'b00);
    add(1, 3'b100, 3'b010, 0, 3'b100, 3'b010, 0, 2'b00);
    // Conflict: flash 4 red / 4 off, then clear with legal inputs.
    add(1, 3'b001, 3'b001, 0, 3'b100, 3'b010, 0, 2'b00);
    add(4, 3'b001, 3'b001, 0, 3'b100, 3'b100, 1, 2'b10);
    add(4, 3'b001, 3'b001, 0, 3'b000, 3'b000, 1, 2'b10);
    add(1, 3'b001, 3'b001, 0, 3'b100, 3'b100, 1, 2'b10);
    add(1, 3'b100, 3'b001, 0, 3'b100, 3'b100, 1, 2'b10);
    add(1, 3'b100, 3'b001, 1, 3'b100, 3'b100, 1, 2'b10);
    add(1, 3'b100, 3'b001, 0, 3'b100, 3'b100, 1, 2'b10);
    add(1, 3'b100, 3'b001, 0, 3'b100, 3'b001, 0, 2'b00);
    // Illegal code keeps its cause; clear is ignored while inputs are illegal.
    add(1, 3'b011, 3'b100, 0, 3'b100, 3'b001, 0, 2'b00);
    add(1, 3'b011, 3'b100, 0, 3'b100, 3'b100, 1, 2'b01);
    add(2, 3'b011, 3'b001, 0, 3'b100, 3'b100, 1, 2'b01);
    add(1, 3'b011, 3'b001, 1, 3'b100, 3'b100, 1, 2'b01);
    add(1, 3'b100, 3'b001, 0, 3'b000, 3'b000, 1, 2'b01);
    add(1, 3'b100, 3'b001, 1, 3'b100, 3'b100, 1, 2'b01);
    add(1, 3'b100, 3'b001, 0, 3'b100, 3'b100, 1, 2'b01);
    add(1, 3'b100, 3'b001, 0, 3'b100, 3'b001, 0, 2'b00);

    rst_n = 1'b0;
    bus.highway = 3'b100;
    bus.side_road = 3'b100;
    bus.clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 3'b100, 3'b100, 0, 2'b00);
`ifdef FAULT_COUNT_EN
    chk("reset count", bus.fault_count, 8'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].hw, tbl[i].sr, tbl[i].clr);
      chk_out($sformatf("row%0d", i + 1), tbl[i].ehw, tbl[i].esr, tbl[i].ef, tbl[i].ec);
    end
`ifdef FAULT_COUNT_EN
    chk("count after two faults", bus.fault_count, 8'd2);
`endif

    // Watchdog: the held value is shown for exactly 64 cycles before flashing.
    step(3'b001, 3'b100, 0);
    chk_out("wd start", 3'b100, 3'b001, 0, 2'b00);
    for (int k = 1; k <= 64; k++) begin
      step(3'b001, 3'b100, 0);
      if (bus.fault !== 1'b0 || {bus.hw_lamp, bus.sr_lamp} !== 6'b001100) begin
        chk_out($sformatf("wd early %0d", k), 3'b001, 3'b100, 0, 2'b00);
      end
    end
    n_cmp++;
    step(3'b001, 3'b100, 0);
    chk_out("wd trip", 3'b100, 3'b100, 1, 2'b11);
`ifdef FAULT_COUNT_EN
    chk("count after watchdog", bus.fault_count, 8'd3);
`endif
    repeat (3) step(3'b001, 3'b100, 0);
    chk_out("wd red end", 3'b100, 3'b100, 1, 2'b11);
    step(3'b001, 3'b100, 0);
    chk_out("wd dark", 3'b000, 3'b000, 1, 2'b11);

    // Asynchronous reset mid-flash, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async reset", 3'b100, 3'b100, 0, 2'b00);
`ifdef FAULT_COUNT_EN
    chk("async reset count", bus.fault_count, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
